// File: rtl/mos6502_timer_responder_if.sv
// CPU-side bus bundle for the 6502 timer responder: cycle strobe, address,
// direction and the READY stretch line. The 8-bit data bus is bidirectional
// and is carried as a separate inout port on the responder.
interface mos6502_timer_responder_if;
    logic        CLK_en;
    logic [15:0] Address_bus;
    logic        RnW;
    logic        READY;

    modport master (output CLK_en, Address_bus, RnW, input READY);
    modport slave  (input CLK_en, Address_bus, RnW, output READY);
endinterface

// File: rtl/mos6502_timer_responder.sv
// 16-byte memory-mapped responder for the 6502 core. It holds one 16-bit
// interval down-counter and one falling-edge capture input, and raises nIRQ.
// Selected reads are stretched by WAIT_STATES CLK_en cycles through READY.
module mos6502_timer_responder #(
    parameter logic [15:0] BASE        = 16'hFE40,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                            CLK,
    input  logic                            nRESET,
    mos6502_timer_responder_if.slave        bus,
    inout  wire  [7:0]                      Data_bus,
    input  logic                            EXT_in,
    output logic                            nIRQ
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [1:0] WS = 2'(WAIT_STATES);

    state_t      state;
    logic [1:0]  wait_cnt;
    logic [7:0]  t1ll, t1lh, scr, rd_q, rd_d;
    logic [15:0] cnt;
    logic        armed;
    logic [1:0]  ifr, ier, ctrl;
    logic        nirq_q;
    logic        live;           // low for the cycle after a reset edge
    logic        ext_s1, ext_s2, ext_s3;

    logic        en, sel, wr, stretch, rd_final;
    logic        wr_t1lh, wr_ifr, rd_t1cl, uf, ext_fall;
    logic [3:0]  off;
    logic [7:0]  din;

    assign en       = bus.CLK_en;
    assign sel      = (bus.Address_bus[15:4] == BASE[15:4]);
    assign off      = bus.Address_bus[3:0];
    assign din      = Data_bus;
    assign wr       = en & sel & ~bus.RnW;
    assign wr_t1lh  = wr & (off == 4'h1);
    assign wr_ifr   = wr & (off == 4'h4);
    assign rd_final = en & sel & bus.RnW & bus.READY;
    assign rd_t1cl  = rd_final & (off == 4'h2);
    // A T1LH write in the same cycle suppresses the underflow entirely.
    assign uf       = en & (cnt == 16'h0000) & armed & ~wr_t1lh;
    assign ext_fall = ext_s3 & ~ext_s2;

    // Stretch a selected read until the wait count is satisfied.
    always_comb begin
        stretch = 1'b0;
        if (sel && bus.RnW)
            stretch = (state == IDLE) ? (WS != 2'd0) : (wait_cnt < WS);
    end

    // While the reset is being applied the bus is released and never stretched.
    assign bus.READY = ~(live & stretch);
    assign Data_bus  = (live && sel && bus.RnW) ? rd_q : 8'hzz;
    assign nIRQ      = nirq_q;

    // Register read mux; unmapped offsets read as zero.
    always_comb begin
        rd_d = 8'h00;
        case (off)
            4'h0:    rd_d = t1ll;
            4'h1:    rd_d = t1lh;
            4'h2:    rd_d = cnt[7:0];
            4'h3:    rd_d = cnt[15:8];
            4'h4:    rd_d = {|(ifr & ier), 5'b0, ifr};
            4'h5:    rd_d = {1'b1, 5'b0, ier};
            4'h6:    rd_d = {6'b0, ctrl};
            4'h7:    rd_d = scr;
            default: rd_d = 8'h00;
        endcase
    end

    // Read wait-state FSM: one pass through WAIT per selected read.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state    <= IDLE;
            wait_cnt <= 2'd0;
        end else begin
            case (state)
                IDLE: if (en && sel && bus.RnW && WS != 2'd0) begin
                    state    <= WAIT;
                    wait_cnt <= 2'd1;
                end
                WAIT: if (!sel || !bus.RnW) begin
                    state    <= IDLE;
                    wait_cnt <= 2'd0;
                end else if (en) begin
                    if (wait_cnt == WS) begin
                        state    <= IDLE;
                        wait_cnt <= 2'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    // Register file, interval timer, flags, edge sync and interrupt output.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            t1ll   <= 8'h00;
            t1lh   <= 8'h00;
            scr    <= 8'h00;
            rd_q   <= 8'h00;
            cnt    <= 16'h0000;
            armed  <= 1'b0;
            ifr    <= 2'b00;
            ier    <= 2'b00;
            ctrl   <= 2'b00;
            nirq_q <= 1'b1;
            live   <= 1'b0;
            ext_s1 <= 1'b1;
            ext_s2 <= 1'b1;
            ext_s3 <= 1'b1;
        end else begin
            live   <= 1'b1;
            rd_q   <= rd_d;
            ext_s1 <= EXT_in;
            ext_s2 <= ext_s1;
            ext_s3 <= ext_s2;
            nirq_q <= ~|(ifr & ier);

            if (wr) begin
                case (off)
                    4'h0:    t1ll <= din;
                    4'h1:    t1lh <= din;
                    4'h5:    ier  <= din[7] ? (ier | din[1:0]) : (ier & ~din[1:0]);
                    4'h6:    ctrl <= din[1:0];
                    4'h7:    scr  <= din;
                    default: ;
                endcase
            end

            if (wr_t1lh) begin
                cnt   <= {din, t1ll};
                armed <= 1'b1;
            end else if (en) begin
                if (cnt != 16'h0000) begin
                    cnt <= cnt - 16'd1;
                end else if (armed) begin
                    if (ctrl[0]) begin
                        cnt <= {t1lh, t1ll};
                    end else begin
                        cnt   <= 16'hFFFF;
                        armed <= 1'b0;
                    end
                end else begin
                    cnt <= 16'hFFFF;
                end
            end

            // Flag sets take precedence over every clear source.
            if (uf)
                ifr[0] <= 1'b1;
            else if (wr_t1lh || (wr_ifr && din[0]) || rd_t1cl)
                ifr[0] <= 1'b0;

            if (ext_fall && ctrl[1])
                ifr[1] <= 1'b1;
            else if (wr_ifr && din[1])
                ifr[1] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mos6502_timer_responder.sv
// Self-checking bench for mos6502_timer_responder. Read data is predicted
// when each read is issued, queued, and compared when READY releases it.
module tb_mos6502_timer_responder;
    localparam int WS = 1;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic       EXT_in = 1'b1;
    logic       nIRQ;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    wire  [7:0] Data_bus;

    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    mos6502_timer_responder_if bus();

    assign Data_bus = drv_en ? drv_val : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (Data_bus[g]);
    end

    mos6502_timer_responder #(.BASE(16'hFE40), .WAIT_STATES(WS)) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .bus      (bus),
        .Data_bus (Data_bus),
        .EXT_in   (EXT_in),
        .nIRQ     (nIRQ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input logic en);
        bus.CLK_en = en;
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        bus.Address_bus = 16'h0000;
        bus.RnW         = 1'b1;
        drv_en          = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        EXT_in = 1'b1;
        nRESET = 1'b0;
        tick(1'b0);
        nRESET = 1'b1;
        tick(1'b0);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus.Address_bus = a;
        bus.RnW         = 1'b0;
        drv_val         = d;
        drv_en          = 1'b1;
        tick(1'b1);
        bus_idle();
    endtask

    // Issue a read, push the prediction, and check it on the READY=1 cycle.
    task automatic bus_read(input logic [15:0] a, input logic [7:0] e, input string nm);
        logic [7:0] got, want;
        int         waits;
        bit         done;
        exp_q.push_back(e);
        bus.Address_bus = a;
        bus.RnW         = 1'b1;
        drv_en          = 1'b0;
        bus.CLK_en      = 1'b1;
        waits = 0;
        done  = 1'b0;
        got   = 8'h00;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if (bus.READY) begin
                got  = Data_bus;
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge CLK);
            #1;
        end
        want = exp_q.pop_front();
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s: READY stayed low, data expected %h", nm, want);
        end else if (got !== want) begin
            n_err++;
            $display("FAIL %s: read %h expected %h", nm, got, want);
        end
        n_vec++;
        if (waits != WS) begin
            n_err++;
            $display("FAIL %s_wait: %0d wait cycles expected %0d", nm, waits, WS);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.READY !== 1'b1) begin n_err++; $display("FAIL rst_ready: %b expected 1", bus.READY); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL rst_nirq: %b expected 1", nIRQ); end
        n_vec++;
        if (Data_bus !== 8'hFF) begin n_err++; $display("FAIL rst_hiz: %h expected released (ff)", Data_bus); end
        bus_read(16'hFE42, 8'h00, "rst_t1cl");
        bus_read(16'hFE43, 8'hFF, "rst_t1ch_wrap");
        bus_read(16'hFE44, 8'h00, "rst_ifr");
        bus_read(16'hFE45, 8'h80, "rst_ier");
        bus_read(16'hFE40, 8'h00, "rst_t1ll");
        bus_read(16'hFE41, 8'h00, "rst_t1lh");
        bus_read(16'hFE46, 8'h00, "rst_ctrl");
        bus_read(16'hFE47, 8'h00, "rst_scr");
        for (int i = 8; i < 16; i++)
            bus_read(16'hFE40 + 16'(i), 8'h00, "unmapped");
    endtask

    task automatic test_freerun();
        do_reset();
        bus_write(16'hFE40, 8'h05);
        bus_write(16'hFE41, 8'h00);            // cnt=5
        bus_write(16'hFE45, 8'h82);            // cnt=4
        bus_write(16'hFE46, 8'h01);            // cnt=3
        bus_read(16'hFE42, 8'h03, "fr_cnt3");  // -> 1
        bus_read(16'hFE43, 8'h00, "fr_cnth");  // -> 0, then flag + reload 5
        bus_read(16'hFE44, 8'h01, "fr_ifr0");  // -> 3
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL fr_nirq_masked: %b expected 1", nIRQ); end
        bus_write(16'hFE45, 8'h81);            // cnt=2
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL fr_nirq_lag: %b expected 1", nIRQ); end
        tick(1'b0);
        n_vec++;
        if (nIRQ !== 1'b0) begin n_err++; $display("FAIL fr_nirq_on: %b expected 0", nIRQ); end
        bus_read(16'hFE44, 8'h81, "fr_ifr_irq"); // -> 0
        bus_read(16'hFE42, 8'h00, "fr_cnt0");    // reload 5 -> 4, flag cleared
        bus_read(16'hFE42, 8'h04, "fr_reload");  // -> 2
        bus_read(16'hFE44, 8'h00, "fr_rdclr");
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL fr_nirq_off: %b expected 1", nIRQ); end
    endtask

    task automatic test_oneshot();
        do_reset();
        bus_write(16'hFE40, 8'h02);
        bus_write(16'hFE41, 8'h00);            // cnt=2
        bus_write(16'hFE45, 8'h81);            // cnt=1
        tick(1'b1);                            // 0
        tick(1'b1);                            // flag, FFFF, disarm
        bus_read(16'hFE44, 8'h81, "os_flag");  // -> FFFD
        bus_read(16'hFE43, 8'hFF, "os_wrap");  // -> FFFB
        bus_read(16'hFE42, 8'hFB, "os_cntl");  // -> FFF9, clears flag
        bus_read(16'hFE44, 8'h00, "os_rdclr"); // -> FFF7
        bus_idle();
        for (int i = 0; i < 65540; i++) tick(1'b1); // -> FFF3
        bus_read(16'hFE44, 8'h00, "os_no_reflag");
        bus_read(16'hFE42, 8'hF1, "os_silent_cnt");
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL os_nirq: %b expected 1", nIRQ); end
    endtask

    task automatic test_priority();
        do_reset();
        bus_write(16'hFE40, 8'h01);
        bus_write(16'hFE41, 8'h00);            // cnt=1
        bus_write(16'hFE46, 8'h01);            // cnt=0
        bus_write(16'hFE44, 8'h01);            // underflow vs write-clear
        bus_read(16'hFE44, 8'h01, "pr_set_beats_wrclr");
        bus_read(16'hFE42, 8'h01, "pr_cnt1");  // final cycle: underflow vs read-clear
        bus_read(16'hFE44, 8'h01, "pr_set_beats_rdclr");
        bus_idle();
        tick(1'b1);                            // cnt=0
        bus_write(16'hFE41, 8'h00);            // load vs underflow
        bus_read(16'hFE44, 8'h00, "pr_load_beats_uf");
        bus_read(16'hFE42, 8'h01, "pr_reload");
    endtask

    task automatic test_ext();
        do_reset();
        bus_write(16'hFE46, 8'h02);
        bus_write(16'hFE45, 8'h82);
        EXT_in = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL ext_nirq_lag: %b expected 1", nIRQ); end
        tick(1'b0);
        n_vec++;
        if (nIRQ !== 1'b0) begin n_err++; $display("FAIL ext_nirq: %b expected 0", nIRQ); end
        EXT_in = 1'b1;
        bus_read(16'hFE44, 8'h82, "ext_flag");
        bus_idle();
        for (int i = 0; i < 3; i++) tick(1'b0);
        EXT_in = 1'b0;
        tick(1'b0);
        tick(1'b0);
        bus_write(16'hFE44, 8'h02);            // clear in the same cycle as the edge
        EXT_in = 1'b1;
        bus_read(16'hFE44, 8'h82, "ext_set_beats_clr");
        bus_write(16'hFE44, 8'h02);
        bus_read(16'hFE44, 8'h00, "ext_wrclr");
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL ext_nirq_off: %b expected 1", nIRQ); end
        bus_write(16'hFE46, 8'h00);
        EXT_in = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        EXT_in = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        bus_read(16'hFE44, 8'h00, "ext_disabled");
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus_write(16'hFE47, 8'h5A);
        bus_write(16'hFE45, 8'h82);
        bus_write(16'hFE46, 8'h02);
        EXT_in = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b0);
        EXT_in = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        n_vec++;
        if (nIRQ !== 1'b0) begin n_err++; $display("FAIL mr_nirq_pre: %b expected 0", nIRQ); end
        bus.Address_bus = 16'hFE47;
        bus.RnW         = 1'b1;
        bus.CLK_en      = 1'b1;
        #1;
        n_vec++;
        if (bus.READY !== 1'b0) begin n_err++; $display("FAIL mr_ready_wait: %b expected 0", bus.READY); end
        nRESET = 1'b0;
        @(posedge CLK);
        #1;
        n_vec++;
        if (bus.READY !== 1'b1) begin n_err++; $display("FAIL mr_ready: %b expected 1", bus.READY); end
        n_vec++;
        if (Data_bus !== 8'hFF) begin n_err++; $display("FAIL mr_hiz: %h expected released (ff)", Data_bus); end
        n_vec++;
        if (nIRQ !== 1'b1) begin n_err++; $display("FAIL mr_nirq: %b expected 1", nIRQ); end
        bus_idle();
        nRESET = 1'b1;
        tick(1'b0);
        bus_read(16'hFE47, 8'h00, "mr_scr");
        bus_read(16'hFE45, 8'h80, "mr_ier");
        bus_read(16'hFE46, 8'h00, "mr_ctrl");
        bus_read(16'hFE44, 8'h00, "mr_ifr");
    endtask

    task automatic test_outside();
        do_reset();
        bus_write(16'hFE40, 8'h33);
        bus_write(16'hFE50, 8'h77);
        bus_write(16'hFE57, 8'h99);
        bus_write(16'hFE3F, 8'h11);
        bus.Address_bus = 16'hFE50;
        bus.RnW         = 1'b1;
        bus.CLK_en      = 1'b1;
        #1;
        n_vec++;
        if (bus.READY !== 1'b1) begin n_err++; $display("FAIL out_ready: %b expected 1", bus.READY); end
        tick(1'b1);
        n_vec++;
        if (Data_bus !== 8'hFF) begin n_err++; $display("FAIL out_hiz: %h expected released (ff)", Data_bus); end
        bus_read(16'hFE40, 8'h33, "out_t1ll");
        bus_read(16'hFE47, 8'h00, "out_scr");
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus_write(16'hFE47, 8'hA5);
        bus.Address_bus = 16'hFE47;
        bus.RnW         = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0);
        n_vec++;
        if (bus.READY !== 1'b0) begin n_err++; $display("FAIL b2b_gated: %b expected 0", bus.READY); end
        bus_read(16'hFE47, 8'hA5, "b2b_first");
        bus_read(16'hFE45, 8'h80, "b2b_second");
        bus_read(16'hFE47, 8'hA5, "b2b_third");
        bus_idle();
    endtask

    initial begin
        bus_idle();
        bus.CLK_en = 1'b0;
        test_reset();
        test_freerun();
        test_oneshot();
        test_priority();
        test_ext();
        test_reset_mid_wait();
        test_outside();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
